// File: rtl/inst_issue_queue_if.sv
// Upstream instruction push bus (valid/ready/data) feeding inst_issue_queue.
interface inst_issue_queue_if #(
    parameter int INST_BITS = 48
);
    logic                 s_inst_valid;
    logic                 s_inst_ready;
    logic [INST_BITS-1:0] s_inst_data;

    modport master (output s_inst_valid, output s_inst_data, input s_inst_ready);
    modport slave  (input s_inst_valid, input s_inst_data, output s_inst_ready);
endinterface

// File: rtl/inst_issue_queue.sv
// Instruction FIFO that issues one word per array slot (falling edge of flag).
// Optional performance counters enabled by defining INST_ISSUE_PERF_EN.
module inst_issue_queue #(
    parameter int                   INST_BITS  = 48,
    parameter int                   DEPTH_LOG2 = 4,
    parameter logic [INST_BITS-1:0] IDLE_WORD  = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    inst_issue_queue_if.slave     s_inst,
    input  logic                  issue_en,
    input  logic                  flush,
    input  logic                  flag,
    input  logic                  idle_flag,
    output logic [INST_BITS-1:0]  instruction,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  all_done,
    output logic [31:0]           issued_cnt,
    output logic [31:0]           idle_slot_cnt
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [INST_BITS-1:0] mem [DEPTH];
    logic [DEPTH_LOG2:0]  wr_ptr_reg, wr_ptr_next;
    logic [DEPTH_LOG2:0]  rd_ptr_reg, rd_ptr_next;
    logic                 flag_q_reg;
    logic [INST_BITS-1:0] instruction_reg, instruction_next;

    logic empty, full, push, slot_end, pop;

    // Pointer MSBs differ only when the write side has lapped the read side.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[DEPTH_LOG2] != rd_ptr_reg[DEPTH_LOG2]) &&
                   (wr_ptr_reg[DEPTH_LOG2-1:0] == rd_ptr_reg[DEPTH_LOG2-1:0]);

    assign s_inst.s_inst_ready = !full;
    assign push     = s_inst.s_inst_valid && !full && !flush;
    assign slot_end = flag_q_reg && !flag;
    assign pop      = slot_end && issue_en && !empty && !flush;

    always_comb begin
        wr_ptr_next      = wr_ptr_reg;
        rd_ptr_next      = rd_ptr_reg;
        instruction_next = instruction_reg;
        if (flush) begin
            rd_ptr_next = wr_ptr_reg;
        end else begin
            if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
        end
        if (pop)
            instruction_next = mem[rd_ptr_reg[DEPTH_LOG2-1:0]];
        else if (slot_end)
            instruction_next = IDLE_WORD;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg[DEPTH_LOG2-1:0]] <= s_inst.s_inst_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            flag_q_reg      <= 1'b0;
            instruction_reg <= IDLE_WORD;
        end else begin
            wr_ptr_reg      <= wr_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
            flag_q_reg      <= flag;
            instruction_reg <= instruction_next;
        end
    end

    assign instruction = instruction_reg;
    assign fifo_count  = wr_ptr_reg - rd_ptr_reg;
    assign all_done    = empty && (instruction_reg == IDLE_WORD) && idle_flag;

`ifdef INST_ISSUE_PERF_EN
    logic [31:0] issued_cnt_reg;
    logic [31:0] idle_slot_cnt_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            issued_cnt_reg    <= '0;
            idle_slot_cnt_reg <= '0;
        end else begin
            if (pop)
                issued_cnt_reg <= issued_cnt_reg + 32'd1;
            else if (slot_end)
                idle_slot_cnt_reg <= idle_slot_cnt_reg + 32'd1;
        end
    end

    assign issued_cnt    = issued_cnt_reg;
    assign idle_slot_cnt = idle_slot_cnt_reg;
`else
    assign issued_cnt    = '0;
    assign idle_slot_cnt = '0;
`endif
endmodule

// File: tb/tb_inst_issue_queue.sv
// Directed bench for inst_issue_queue: slot issue, full/empty, flush and reset.
module tb_inst_issue_queue;
    localparam int          INST_BITS  = 48;
    localparam int          DEPTH_LOG2 = 4;
    localparam logic [47:0] IDLE       = 48'h0000_0000_0007;
`ifdef INST_ISSUE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 issue_en, flush, flag, idle_flag;
    logic [INST_BITS-1:0] instruction;
    logic [DEPTH_LOG2:0]  fifo_count;
    logic                 all_done;
    logic [31:0]          issued_cnt, idle_slot_cnt;

    int checks = 0;
    int errors = 0;

    inst_issue_queue_if #(.INST_BITS(INST_BITS)) bus ();

    inst_issue_queue #(
        .INST_BITS (INST_BITS),
        .DEPTH_LOG2(DEPTH_LOG2),
        .IDLE_WORD (IDLE)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_inst       (bus),
        .issue_en     (issue_en),
        .flush        (flush),
        .flag         (flag),
        .idle_flag    (idle_flag),
        .instruction  (instruction),
        .fifo_count   (fifo_count),
        .all_done     (all_done),
        .issued_cnt   (issued_cnt),
        .idle_slot_cnt(idle_slot_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [47:0] w);
        bus.s_inst_valid = 1'b1;
        bus.s_inst_data  = w;
        tick();
        bus.s_inst_valid = 1'b0;
    endtask

    task automatic pulse(input int hi);
        flag = 1'b1;
        repeat (hi) tick();
        flag = 1'b0;
        tick();
    endtask

    task automatic check_cnts(input string tag, input int iss, input int idl);
        check_eq({tag, "_issued"}, issued_cnt, PERF ? iss : 0);
        check_eq({tag, "_idle"}, idle_slot_cnt, PERF ? idl : 0);
    endtask

    initial begin
        reset_n = 1'b0;
        issue_en = 1'b1; flush = 1'b0; flag = 1'b0; idle_flag = 1'b1;
        bus.s_inst_valid = 1'b0; bus.s_inst_data = '0;
        repeat (3) tick();
        check_eq("rst_instr", instruction, IDLE);
        check_eq("rst_count", fifo_count, 0);
        check_eq("rst_ready", bus.s_inst_ready, 1);
        check_eq("rst_all_done", all_done, 1);
        check_cnts("rst", 0, 0);
        reset_n = 1'b1;
        tick();

        // Three slots with nothing queued
        for (int i = 0; i < 3; i++) begin
            pulse(1);
            check_eq("empty_instr", instruction, IDLE);
            check_eq("empty_all_done", all_done, 1);
        end
        idle_flag = 1'b0;
        #1 check_eq("all_done_busy", all_done, 0);
        idle_flag = 1'b1;
        check_cnts("empty", 0, 3);

        // A, B, C issued in order, one edge after flag falls
        push(48'hA0A0_0000_000A);
        push(48'hB0B0_0000_000B);
        push(48'hC0C0_0000_000C);
        check_eq("abc_count", fifo_count, 3);
        check_eq("abc_not_done", all_done, 0);
        flag = 1'b1;
        tick();
        check_eq("abc_hold_hi", instruction, IDLE);
        flag = 1'b0;
        tick();
        check_eq("abc_A", instruction, 48'hA0A0_0000_000A);
        tick();
        check_eq("abc_A_stable", instruction, 48'hA0A0_0000_000A);
        pulse(1);
        check_eq("abc_B", instruction, 48'hB0B0_0000_000B);
        pulse(1);
        check_eq("abc_C", instruction, 48'hC0C0_0000_000C);
        pulse(1);
        check_eq("abc_idle", instruction, IDLE);
        check_cnts("abc", 3, 4);

        // Fill to 16, 17th rejected, then drain in order
        for (int i = 0; i < 16; i++) push(48'h1000 + 48'(i));
        check_eq("full_count", fifo_count, 16);
        check_eq("full_ready", bus.s_inst_ready, 0);
        push(48'hDEAD);
        check_eq("full_reject_count", fifo_count, 16);
        pulse(1);
        check_eq("full_first", instruction, 48'h1000);
        check_eq("full_count15", fifo_count, 15);
        check_eq("full_ready_again", bus.s_inst_ready, 1);
        for (int i = 1; i < 16; i++) begin
            pulse(1);
            check_eq("drain_word", instruction, 48'h1000 + 48'(i));
        end
        check_eq("drain_count", fifo_count, 0);
        pulse(1);
        check_eq("drain_no_17th", instruction, IDLE);
        check_cnts("full", 19, 5);

        // Issue disabled holds the FIFO
        issue_en = 1'b0;
        push(48'h5555_0000_0001);
        push(48'h5555_0000_0002);
        for (int i = 0; i < 2; i++) begin
            pulse(1);
            check_eq("dis_instr", instruction, IDLE);
            check_eq("dis_count", fifo_count, 2);
        end
        issue_en = 1'b1;
        pulse(1);
        check_eq("en_first", instruction, 48'h5555_0000_0001);
        check_eq("en_count", fifo_count, 1);
        check_cnts("dis", 20, 7);

        // Long flag high is one slot; flag held low issues nothing
        pulse(5);
        check_eq("long_instr", instruction, 48'h5555_0000_0002);
        check_eq("long_count", fifo_count, 0);
        push(48'h7777_0000_0001);
        repeat (3) tick();
        check_eq("low_hold", instruction, 48'h5555_0000_0002);
        check_eq("low_count", fifo_count, 1);
        check_cnts("long", 21, 7);

        // Push and pop on the same edge
        flag = 1'b1;
        tick();
        flag = 1'b0;
        bus.s_inst_valid = 1'b1;
        bus.s_inst_data  = 48'h7777_0000_0002;
        tick();
        bus.s_inst_valid = 1'b0;
        check_eq("pp_count", fifo_count, 1);
        check_eq("pp_instr", instruction, 48'h7777_0000_0001);
        pulse(1);
        check_eq("pp_next", instruction, 48'h7777_0000_0002);
        check_cnts("pp", 23, 7);

        // Flush drops queue and coincident push, instruction unaffected
        for (int i = 0; i < 4; i++) push(48'hF000 + 48'(i));
        pulse(1);
        check_eq("fl_issue", instruction, 48'hF000);
        check_eq("fl_pre_count", fifo_count, 3);
        flush = 1'b1;
        bus.s_inst_valid = 1'b1;
        bus.s_inst_data  = 48'hBAD0;
        tick();
        flush = 1'b0;
        bus.s_inst_valid = 1'b0;
        check_eq("fl_count", fifo_count, 0);
        check_eq("fl_instr", instruction, 48'hF000);
        check_eq("fl_ready", bus.s_inst_ready, 1);
        pulse(1);
        check_eq("fl_dropped", instruction, IDLE);
        push(48'h6666);
        flag = 1'b1;
        tick();
        flag = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("fl_slot_idle", instruction, IDLE);
        check_eq("fl_slot_count", fifo_count, 0);
        check_cnts("fl", 24, 9);

        // Asynchronous reset mid-slot
        push(48'h8888);
        pulse(1);
        check_eq("ar_pre", instruction, 48'h8888);
        push(48'h9999);
        flag = 1'b1;
        tick();
        #2 reset_n = 1'b0;
        #1 check_eq("ar_instr", instruction, IDLE);
        check_eq("ar_count", fifo_count, 0);
        tick();
        reset_n = 1'b1;
        check_cnts("ar", 0, 0);
        // flag still high at release: its fall is a slot end
        tick();
        flag = 1'b0;
        tick();
        check_eq("ar_first_fall", instruction, IDLE);
        check_cnts("ar_fall", 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
